// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data-side SRAM responder: MMIO window base,
// register offsets within the window, and register reset values.
package data_sram_resp_pkg;

   localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hBFAF_0000;

   localparam logic [15:0] OFF_CR0        = 16'h0000;
   localparam logic [15:0] OFF_TIMER      = 16'h0100;
   localparam logic [15:0] OFF_TIMER_CMP  = 16'h0104;
   localparam logic [15:0] OFF_TIMER_STAT = 16'h0108;
   localparam logic [15:0] OFF_LED        = 16'h0200;

   localparam logic [31:0] TIMER_CMP_RST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_sram_resp_sram_1rw.sv
// Single-port word RAM: read-first, registered output, array and output
// register deliberately left without reset.
module sram_1rw #(
   parameter int AW = 14,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Stage p0 -> p1: write and read share the edge; the read sees the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: decodes each request into the MMIO register file
// (scratch, timer, LED) or the internal word RAM and returns read data one cycle later.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int          RAM_AW    = 14,
   parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic        timer_irq
);

   logic        is_mmio;
   logic        hit_cr;
   logic        hit_timer;
   logic        hit_cmp;
   logic        hit_stat;
   logic        hit_led;
   logic [2:0]  cr_idx;
   logic        mmio_we;
   logic        ram_we;
   logic        timer_match;

   logic [31:0] cr_q [8];
   logic [31:0] timer_q;
   logic [31:0] timer_cmp_q;
   logic        pend_q;
   logic [15:0] led_q;

   logic [31:0] mmio_rd;
   logic [31:0] mmio_rdata_p1;
   logic        mmio_sel_p1;
   logic [31:0] ram_rdata_p1;
   logic        unused_addr;

   assign is_mmio   = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
   assign hit_cr    = (data_sram_addr[15:5] == OFF_CR0[15:5]);
   assign hit_timer = (data_sram_addr[15:2] == OFF_TIMER[15:2]);
   assign hit_cmp   = (data_sram_addr[15:2] == OFF_TIMER_CMP[15:2]);
   assign hit_stat  = (data_sram_addr[15:2] == OFF_TIMER_STAT[15:2]);
   assign hit_led   = (data_sram_addr[15:2] == OFF_LED[15:2]);
   assign cr_idx    = data_sram_addr[4:2];

   assign mmio_we     = data_sram_we && is_mmio;
   // Gating with resetn drops a RAM write that coincides with reset.
   assign ram_we      = data_sram_we && !is_mmio && resetn;
   assign timer_match = (timer_q == timer_cmp_q);
   assign unused_addr = ^data_sram_addr[1:0];

   always_comb begin
      mmio_rd = '0;
      if (hit_cr) begin
         mmio_rd = cr_q[cr_idx];
      end else if (hit_timer) begin
         mmio_rd = timer_q;
      end else if (hit_cmp) begin
         mmio_rd = timer_cmp_q;
      end else if (hit_stat) begin
         mmio_rd = {31'd0, pend_q};
      end else if (hit_led) begin
         mmio_rd = {16'd0, led_q};
      end
   end

   sram_1rw #(
      .AW (RAM_AW),
      .DW (32)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (data_sram_addr[RAM_AW+1:2]),
      .wdata (data_sram_wdata),
      .rdata (ram_rdata_p1)
   );

   // Stage p0 -> p1: register updates and MMIO read capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 8; i++) begin
            cr_q[i] <= '0;
         end
         timer_q       <= '0;
         timer_cmp_q   <= TIMER_CMP_RST;
         pend_q        <= 1'b0;
         led_q         <= '0;
         mmio_rdata_p1 <= '0;
         mmio_sel_p1   <= 1'b1;
      end else begin
         if (mmio_we && hit_cr) begin
            cr_q[cr_idx] <= data_sram_wdata;
         end
         if (mmio_we && hit_timer) begin
            timer_q <= data_sram_wdata;
         end else begin
            timer_q <= timer_q + 32'd1;
         end
         if (mmio_we && hit_cmp) begin
            timer_cmp_q <= data_sram_wdata;
         end
         // A compare match wins over a simultaneous write-1-to-clear.
         if (timer_match) begin
            pend_q <= 1'b1;
         end else if (mmio_we && hit_stat && data_sram_wdata[0]) begin
            pend_q <= 1'b0;
         end
         if (mmio_we && hit_led) begin
            led_q <= data_sram_wdata[15:0];
         end
         mmio_rdata_p1 <= mmio_rd;
         mmio_sel_p1   <= is_mmio;
      end
   end

   // Reset forces the MMIO path selected, so rdata reads 0 without touching the RAM.
   assign data_sram_rdata = mmio_sel_p1 ? mmio_rdata_p1 : ram_rdata_p1;
   assign led             = led_q;
   assign timer_irq       = pend_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the register map and RAM.
module tb_data_sram_resp;

   localparam logic [31:0] MB = 32'hBFAF_0000;

   logic        clk;
   logic        resetn;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic [15:0] led;
   logic        timer_irq;

   int total;
   int bad;

   // behavioural model state
   logic [31:0] m_cr [8];
   logic [31:0] m_timer;
   logic [31:0] m_cmp;
   logic        m_pend;
   logic [15:0] m_led;
   logic [31:0] m_ram [int];

   logic [31:0] r_a;
   logic [31:0] r_d;
   logic        r_w;
   int          r_k;

   data_sram_resp dut (
      .clk             (clk),
      .resetn          (resetn),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .led             (led),
      .timer_irq       (timer_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_cr[i] = 32'd0;
      m_timer = 32'd0;
      m_cmp   = 32'hFFFF_FFFF;
      m_pend  = 1'b0;
      m_led   = 16'd0;
   endtask

   function automatic bit is_mmio(input logic [31:0] a);
      return a[31:16] == 16'hBFAF;
   endfunction

   function automatic int word_off(input logic [31:0] a);
      return int'(a[15:0]) & 32'hFFFC;
   endfunction

   task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
      int off;
      known = 1'b1;
      v = 32'd0;
      if (is_mmio(a)) begin
         off = word_off(a);
         if (off < 32'h20)        v = m_cr[off / 4];
         else if (off == 'h100)   v = m_timer;
         else if (off == 'h104)   v = m_cmp;
         else if (off == 'h108)   v = {31'd0, m_pend};
         else if (off == 'h200)   v = {16'd0, m_led};
      end else begin
         int idx;
         idx = int'(a[15:2]);
         if (m_ram.exists(idx)) v = m_ram[idx];
         else known = 1'b0;
      end
   endtask

   // One request cycle: drive, let one edge pass, advance the model, compare.
   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] exp_rd;
      bit          known;
      bit          match;
      bit          timer_written;
      int          off;
      data_sram_we    = we;
      data_sram_addr  = a;
      data_sram_wdata = d;
      model_read(a, exp_rd, known);
      match = (m_timer == m_cmp);
      timer_written = 1'b0;
      @(posedge clk);
      #1;
      if (we && is_mmio(a)) begin
         off = word_off(a);
         if (off < 32'h20)        m_cr[off / 4] = d;
         else if (off == 'h100) begin
            m_timer = d;
            timer_written = 1'b1;
         end
         else if (off == 'h104)   m_cmp = d;
         else if (off == 'h108 && d[0]) m_pend = 1'b0;
         else if (off == 'h200)   m_led = d[15:0];
      end else if (we) begin
         m_ram[int'(a[15:2])] = d;
      end
      if (!timer_written) m_timer = m_timer + 32'd1;
      if (match) m_pend = 1'b1;
      if (known) chk("rdata", data_sram_rdata, exp_rd);
      chk("led", {16'd0, led}, {16'd0, m_led});
      chk("irq", {31'd0, timer_irq}, {31'd0, m_pend});
   endtask

   initial begin
      total = 0;
      bad = 0;
      resetn = 1'b0;
      data_sram_we = 1'b0;
      data_sram_addr = 32'd0;
      data_sram_wdata = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rdata", data_sram_rdata, 32'd0);
      chk("rst_led", {16'd0, led}, 32'd0);
      chk("rst_irq", {31'd0, timer_irq}, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      cyc(0, MB + 32'h104, 0);
      chk("cmp_rst", data_sram_rdata, 32'hFFFF_FFFF);
      cyc(0, MB + 32'h100, 0);
      chk("timer_first", data_sram_rdata, 32'd1);

      // RAM write, read-back, read-first and alias
      cyc(1, 32'h0000_0010, 32'hDEAD_BEEF);
      cyc(0, 32'h0000_0010, 0);
      chk("ram_rd", data_sram_rdata, 32'hDEAD_BEEF);
      cyc(1, 32'h0000_0010, 32'h1);
      chk("ram_rd_first", data_sram_rdata, 32'hDEAD_BEEF);
      cyc(0, 32'h0001_0010, 0);
      chk("ram_alias", data_sram_rdata, 32'h1);

      // LED and unmapped offset
      cyc(1, MB + 32'h200, 32'h1234_ABCD);
      chk("led_val", {16'd0, led}, 32'h0000_ABCD);
      cyc(0, MB + 32'h200, 0);
      chk("led_rd", data_sram_rdata, 32'h0000_ABCD);
      cyc(1, MB + 32'h300, 32'hFFFF_FFFF);
      cyc(0, MB + 32'h300, 0);
      chk("unmapped", data_sram_rdata, 32'd0);

      // scratch registers
      for (int i = 0; i < 8; i++) cyc(1, MB + 32'(4 * i), 32'h100 + 32'(i));
      for (int i = 0; i < 8; i++) begin
         cyc(0, MB + 32'(4 * i), 0);
         chk("scratch", data_sram_rdata, 32'h100 + 32'(i));
      end

      // timer wrap and compare interrupt
      cyc(1, MB + 32'h100, 32'hFFFF_FFFE);
      cyc(1, MB + 32'h104, 32'h0);
      cyc(0, MB + 32'h100, 0);
      chk("timer_pre_wrap", data_sram_rdata, 32'hFFFF_FFFF);
      chk("irq_before", {31'd0, timer_irq}, 32'd0);
      cyc(0, MB + 32'h100, 0);
      chk("timer_wrapped", data_sram_rdata, 32'd0);
      chk("irq_set", {31'd0, timer_irq}, 32'd1);
      cyc(0, MB + 32'h108, 0);
      chk("stat_rd", data_sram_rdata, 32'd1);
      cyc(1, MB + 32'h108, 32'h1);
      chk("irq_clr", {31'd0, timer_irq}, 32'd0);

      // set beats clear
      cyc(1, MB + 32'h100, 32'd10);
      cyc(1, MB + 32'h104, 32'd12);
      cyc(0, MB + 32'h300, 0);
      cyc(1, MB + 32'h108, 32'h1);
      chk("set_beats_clr", {31'd0, timer_irq}, 32'd1);

      // asynchronous reset mid-run; RAM keeps contents, in-flight write dropped
      cyc(1, 32'h0000_0020, 32'hAAAA_AAAA);
      cyc(1, MB + 32'h100, 32'h55);
      cyc(0, MB + 32'h100, 0);
      chk("timer_55", data_sram_rdata, 32'h55);
      data_sram_we = 1'b1;
      data_sram_addr = 32'h0000_0020;
      data_sram_wdata = 32'h5555_5555;
      #3;
      resetn = 1'b0;
      #1;
      chk("midrst_rdata", data_sram_rdata, 32'd0);
      chk("midrst_led", {16'd0, led}, 32'd0);
      chk("midrst_irq", {31'd0, timer_irq}, 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      cyc(0, MB + 32'h104, 0);
      chk("cmp_after_rst", data_sram_rdata, 32'hFFFF_FFFF);
      cyc(0, MB + 32'h100, 0);
      chk("timer_after_rst", data_sram_rdata, 32'd1);
      cyc(0, 32'h0000_0020, 0);
      chk("ram_kept", data_sram_rdata, 32'hAAAA_AAAA);
      cyc(0, MB, 0);
      chk("cr0_after_rst", data_sram_rdata, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 16; i++) cyc(1, 32'h100 + 32'(4 * i), $urandom);
      for (int n = 0; n < 400; n++) begin
         r_k = $urandom_range(0, 9);
         r_d = $urandom;
         r_w = 1'($urandom_range(0, 1));
         case (r_k)
            0, 1, 2, 3: r_a = 32'h100 + 32'(4 * $urandom_range(0, 15))
                            + ($urandom_range(0, 1) != 0 ? 32'h1_0000 : 32'h0)
                            + 32'($urandom_range(0, 3));
            4: r_a = MB + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
            5: r_a = MB + 32'h100;
            6: begin
               r_a = MB + 32'h104;
               r_d = m_timer + 32'($urandom_range(1, 4));
            end
            7: r_a = MB + 32'h108;
            8: r_a = MB + 32'h200;
            default: r_a = MB + ($urandom_range(0, 1) != 0 ? 32'h10C : 32'h300);
         endcase
         cyc(r_w, r_a, r_d);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
